// File: rtl/drap_pkg.sv
// Shared definitions for the DRAP_PC fetch-stage sequencer: state encoding,
// default vectors and PC width.
package drap_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] RESET_VEC_DEF = 32'hBFC0_0000;
    localparam logic [PC_W-1:0] EXC_VEC_DEF   = 32'hBFC0_0380;
    localparam logic [PC_W-1:0] PC_INC_DEF    = 32'd4;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_DSLOT = 2'd2
    } state_t;

    // Branch/jump targets are word addresses; low two bits are dropped on capture.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/drap_pc_seq.sv
// Next-PC sequencer: picks boot vector, sequential, delayed branch/jump target
// or exception vector each cycle and drives the DRAP_PC load port with zero latency.
module drap_pc_seq
    import drap_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [PC_W-1:0] EXC_VEC   = EXC_VEC_DEF,
    parameter logic [PC_W-1:0] PC_INC    = PC_INC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] PC_cur,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            exc,
    output logic [PC_W-1:0] PC_in,
    output logic            PC_load,
    output logic [PC_W-1:0] epc,
    output logic            exc_bd,
    output logic            in_dslot,
    output logic            dslot_err,
    output logic [1:0]      dbg_state_o
);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   tgt_q, tgt_d;
    logic [PC_W-1:0]   epc_q, epc_d;
    logic              exc_bd_q, exc_bd_d;
    logic              dslot_err_q, dslot_err_d;
    logic [PC_W-1:0]   pc_in_c;
    logic              pc_load_c;
    logic [PC_W-1:0]   pc_seq;
    logic [PC_W-1:0]   pc_branch;

    assign pc_seq    = PC_cur + PC_INC;
    assign pc_branch = PC_cur - PC_INC;

    // PC_in/PC_load are sampled by DRAP_PC on the same edge; rst forces a no-load.
    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        epc_d       = epc_q;
        exc_bd_d    = exc_bd_q;
        dslot_err_d = 1'b0;
        pc_in_c     = '0;
        pc_load_c   = 1'b0;
        if (!rst) begin
            unique case (state_q)
                S_BOOT: begin
                    pc_in_c   = RESET_VEC;
                    pc_load_c = 1'b1;
                    state_d   = S_RUN;
                end
                S_RUN: begin
                    if (exc) begin
                        pc_in_c   = EXC_VEC;
                        pc_load_c = 1'b1;
                        epc_d     = PC_cur;
                        exc_bd_d  = 1'b0;
                    end else if (stall) begin
                        pc_in_c   = PC_cur;
                    end else begin
                        pc_in_c   = pc_seq;
                        pc_load_c = 1'b1;
                        if (jmp) begin
                            tgt_d   = word_align(jmp_target);
                            state_d = S_DSLOT;
                        end else if (br_taken) begin
                            tgt_d   = word_align(br_target);
                            state_d = S_DSLOT;
                        end
                    end
                end
                S_DSLOT: begin
                    if (exc) begin
                        // Report the branch itself, not the slot, so restart re-executes it.
                        pc_in_c   = EXC_VEC;
                        pc_load_c = 1'b1;
                        epc_d     = pc_branch;
                        exc_bd_d  = 1'b1;
                        state_d   = S_RUN;
                    end else if (stall) begin
                        pc_in_c   = PC_cur;
                    end else begin
                        pc_in_c     = tgt_q;
                        pc_load_c   = 1'b1;
                        dslot_err_d = jmp | br_taken;
                        state_d     = S_RUN;
                    end
                end
                default: begin
                    state_d = S_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_BOOT;
            tgt_q       <= '0;
            epc_q       <= '0;
            exc_bd_q    <= 1'b0;
            dslot_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            epc_q       <= epc_d;
            exc_bd_q    <= exc_bd_d;
            dslot_err_q <= dslot_err_d;
        end
    end

    assign PC_in       = pc_in_c;
    assign PC_load     = pc_load_c;
    assign epc         = epc_q;
    assign exc_bd      = exc_bd_q;
    assign in_dslot    = (state_q == S_DSLOT);
    assign dslot_err   = dslot_err_q;
    assign dbg_state_o = state_q;

endmodule
